// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer
// Captures 2^ADDR_W six-channel ADC sample-sets into on-chip RAM once
// armed and triggered, then serves them to the processor through a
// registered read port with a new-sample pulse.
//
// Optional feature macro: ZERO_CROSS_TRIG_EN
//   defined   - capture starts on a rising crossing of TRIG_LEVEL on ch1
//   undefined - capture starts on the first strobe after arming
module adc_capture_buffer #(
    parameter int                 ADDR_W     = 12,
    parameter int                 DATA_W     = 8,
    parameter logic [DATA_W-1:0]  TRIG_LEVEL = 8'd128
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [DATA_W-1:0]    adc_ch1,
    input  logic [DATA_W-1:0]    adc_ch2,
    input  logic [DATA_W-1:0]    adc_ch3,
    input  logic [DATA_W-1:0]    adc_ch4,
    input  logic [DATA_W-1:0]    adc_ch5,
    input  logic [DATA_W-1:0]    adc_ch6,
    input  logic                 adc_valid,
    input  logic                 capture_start,
    input  logic [ADDR_W-1:0]    read_address,
    output logic [DATA_W-1:0]    channel1_analog,
    output logic [DATA_W-1:0]    channel2_analog,
    output logic [DATA_W-1:0]    channel3_analog,
    output logic [DATA_W-1:0]    channel4_analog,
    output logic [DATA_W-1:0]    channel5_analog,
    output logic [DATA_W-1:0]    channel6_analog,
    output logic                 read_new_sample,
    output logic                 writing_finish_flag,
    output logic                 capture_busy
);

    localparam int                 WORD_W    = 6 * DATA_W;
    localparam int                 DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0]  ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0]  ZERO_WORD = {WORD_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                arm_s;
    logic                wr_en_s;
    logic                trig_s;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [WORD_W-1:0]   wr_word_s;
    logic                flag_r;
    logic                busy_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [ADDR_W-1:0]   last_addr_r;
    logic [WORD_W-1:0]   rd_word_r;
    logic                new_sample_r;
    logic [WORD_W-1:0]   mem_r [DEPTH];

    // Sample-set word: channel 1 in the least significant byte.
    assign wr_word_s = {adc_ch6, adc_ch5, adc_ch4, adc_ch3, adc_ch2, adc_ch1};

`ifdef ZERO_CROSS_TRIG_EN
    logic [DATA_W-1:0]   prev_ch1_r;
    logic                prev_valid_r;

    // Track the previous ch1 strobe value while armed; cleared on each arm.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_ch1_r   <= {DATA_W{1'b0}};
            prev_valid_r <= 1'b0;
        end else if (arm_s) begin
            prev_ch1_r   <= {DATA_W{1'b0}};
            prev_valid_r <= 1'b0;
        end else if ((state_r == ST_ARMED) && adc_valid) begin
            prev_ch1_r   <= adc_ch1;
            prev_valid_r <= 1'b1;
        end else begin
            prev_ch1_r   <= prev_ch1_r;
            prev_valid_r <= prev_valid_r;
        end
    end

    // Rising crossing of the mid-scale level; the first strobe cannot fire.
    always_comb begin
        trig_s = 1'b0;
        if (prev_valid_r && (prev_ch1_r < TRIG_LEVEL) && (adc_ch1 >= TRIG_LEVEL)) begin
            trig_s = 1'b1;
        end else begin
            trig_s = 1'b0;
        end
    end
`else
    // Without the crossing detector any strobe while armed starts capture.
    always_comb begin
        trig_s = 1'b1;
    end
`endif

    // Capture state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, arm and write-enable decode.
    always_comb begin
        next_state_s = state_r;
        arm_s        = 1'b0;
        wr_en_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (capture_start) begin
                    next_state_s = ST_ARMED;
                    arm_s        = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_ARMED: begin
                if (adc_valid && trig_s) begin
                    wr_en_s = 1'b1;
                    if (wr_ptr_r == LAST_ADDR) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WRITE;
                    end
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            ST_WRITE: begin
                if (adc_valid) begin
                    wr_en_s = 1'b1;
                    if (wr_ptr_r == LAST_ADDR) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WRITE;
                    end
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Write pointer: cleared on arm, advances per write, holds at the top.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_r <= ZERO_ADDR;
        end else if (arm_s) begin
            wr_ptr_r <= ZERO_ADDR;
        end else if (wr_en_s && (wr_ptr_r != LAST_ADDR)) begin
            wr_ptr_r <= wr_ptr_r + ONE_ADDR;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Sample RAM write port; contents survive reset.
    always_ff @(posedge clk_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_word_s;
        end
    end

    // Finish flag follows DONE one edge late; busy covers ARMED/WRITE and
    // is stretched so it drops on the same edge the flag rises.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            flag_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            flag_r <= (state_r == ST_DONE) && !capture_start;
            busy_r <= (next_state_s == ST_ARMED) || (next_state_s == ST_WRITE) ||
                      (state_r == ST_WRITE);
        end
    end

    // Read address register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_addr_r <= ZERO_ADDR;
        end else begin
            rd_addr_r <= read_address;
        end
    end

    // Registered RAM read plus change detection; a same-cycle write to the
    // read address returns the old word.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_word_r    <= ZERO_WORD;
            last_addr_r  <= ZERO_ADDR;
            new_sample_r <= 1'b0;
        end else begin
            rd_word_r    <= mem_r[rd_addr_r];
            last_addr_r  <= rd_addr_r;
            new_sample_r <= flag_r && (rd_addr_r != last_addr_r);
        end
    end

    assign channel1_analog     = rd_word_r[0*DATA_W +: DATA_W];
    assign channel2_analog     = rd_word_r[1*DATA_W +: DATA_W];
    assign channel3_analog     = rd_word_r[2*DATA_W +: DATA_W];
    assign channel4_analog     = rd_word_r[3*DATA_W +: DATA_W];
    assign channel5_analog     = rd_word_r[4*DATA_W +: DATA_W];
    assign channel6_analog     = rd_word_r[5*DATA_W +: DATA_W];
    assign read_new_sample     = new_sample_r;
    assign writing_finish_flag = flag_r;
    assign capture_busy        = busy_r;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Self-checking bench for adc_capture_buffer: randomized strobes/gaps, a
// queue of generated samples and an expected-RAM array as reference model.
module tb_adc_capture_buffer;

    localparam int DEPTH = 4096;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [7:0]  adc_ch1, adc_ch2, adc_ch3, adc_ch4, adc_ch5, adc_ch6;
    logic        adc_valid;
    logic        capture_start;
    logic [11:0] read_address;
    logic [7:0]  channel1_analog, channel2_analog, channel3_analog;
    logic [7:0]  channel4_analog, channel5_analog, channel6_analog;
    logic        read_new_sample;
    logic        writing_finish_flag;
    logic        capture_busy;

    logic [47:0] got_word;
    logic [47:0] exp_mem [DEPTH];
    logic [47:0] stim [$];
    logic [11:0] prev_req;
    bit          model_flag;
    int          n_pass = 0;
    int          n_total = 0;

    adc_capture_buffer dut (
        .clk_clk             (clk_clk),
        .reset_reset_n       (reset_reset_n),
        .adc_ch1             (adc_ch1),
        .adc_ch2             (adc_ch2),
        .adc_ch3             (adc_ch3),
        .adc_ch4             (adc_ch4),
        .adc_ch5             (adc_ch5),
        .adc_ch6             (adc_ch6),
        .adc_valid           (adc_valid),
        .capture_start       (capture_start),
        .read_address        (read_address),
        .channel1_analog     (channel1_analog),
        .channel2_analog     (channel2_analog),
        .channel3_analog     (channel3_analog),
        .channel4_analog     (channel4_analog),
        .channel5_analog     (channel5_analog),
        .channel6_analog     (channel6_analog),
        .read_new_sample     (read_new_sample),
        .writing_finish_flag (writing_finish_flag),
        .capture_busy        (capture_busy)
    );

    always #5 clk_clk = ~clk_clk;

    assign got_word = {channel6_analog, channel5_analog, channel4_analog,
                       channel3_analog, channel2_analog, channel1_analog};

    // Index of the strobe that starts capture, from the trigger rule.
    function automatic int find_trig();
`ifdef ZERO_CROSS_TRIG_EN
        for (int i = 1; i < stim.size(); i++) begin
            if ((stim[i-1][7:0] < 8'd128) && (stim[i][7:0] >= 8'd128)) return i;
        end
        return -1;
`else
        return (stim.size() > 0) ? 0 : -1;
`endif
    endfunction

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic arm();
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        n_total++;
        if (capture_busy !== 1'b1) $display("FAIL arm_busy: got %b want 1", capture_busy);
        else n_pass++;
        n_total++;
        if (writing_finish_flag !== 1'b0) $display("FAIL arm_flag: got %b want 0", writing_finish_flag);
        else n_pass++;
        model_flag = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a);
        bit exp_pulse;
        exp_pulse = (a != prev_req) && model_flag;
        read_address = a;
        step();
        n_total++;
        if (read_new_sample !== 1'b0) $display("FAIL read_early a=%0d: got %b want 0", a, read_new_sample);
        else n_pass++;
        step();
        n_total++;
        if (read_new_sample !== exp_pulse) $display("FAIL read_pulse a=%0d: got %b want %b", a, read_new_sample, exp_pulse);
        else n_pass++;
        n_total++;
        if (got_word !== exp_mem[a]) $display("FAIL read_data a=%0d: got %h want %h", a, got_word, exp_mem[a]);
        else n_pass++;
        step();
        n_total++;
        if (read_new_sample !== 1'b0) $display("FAIL read_width a=%0d: got %b want 0", a, read_new_sample);
        else n_pass++;
        prev_req = a;
    endtask

    // kind: 0 = ramp pattern, 1 = random, 2 = trigger table then random.
    // ignore_at/collide_at/abort_at are write indices, -1 disables.
    task automatic capture(input int kind, input int gap_max, input int ignore_at,
                           input int collide_at, input int abort_at);
        logic [7:0]  zc_seq [5];
        logic [47:0] w;
        int          trig, wi;
        zc_seq = '{8'd200, 8'd100, 8'd127, 8'd128, 8'd130};
        stim.delete();
        for (int i = 0; i < DEPTH + 400; i++) begin
            w = {$urandom(), $urandom()};
            if (kind == 0) begin
                for (int n = 1; n <= 6; n++) w[(n-1)*8 +: 8] = 8'(i + n);
            end else if ((kind == 2) && (i < 5)) begin
                w[7:0] = zc_seq[i];
            end
            stim.push_back(w);
        end
        trig = find_trig();
        n_total++;
        if (trig < 0) begin
            $display("FAIL trigger_search: got %0d want >=0", trig);
            return;
        end
        n_pass++;
        for (int s = 0; s <= trig + DEPTH - 1; s++) begin
            wi = s - trig;
            if (wi == abort_at) begin
                for (int k = 0; k < abort_at; k++) exp_mem[k] = stim[trig + k];
                reset_reset_n = 1'b0;
                #2;
                n_total++;
                if ({got_word, read_new_sample, writing_finish_flag, capture_busy} !== 51'd0)
                    $display("FAIL abort_reset: got %h/%b/%b/%b want all 0", got_word,
                             read_new_sample, writing_finish_flag, capture_busy);
                else n_pass++;
                step();
                reset_reset_n = 1'b1;
                step();
                n_total++;
                if ({writing_finish_flag, capture_busy} !== 2'b00)
                    $display("FAIL abort_idle: got %b%b want 00", writing_finish_flag, capture_busy);
                else n_pass++;
                return;
            end
            if (wi == collide_at) begin
                read_address = 12'(wi);
                prev_req = 12'(wi);
                step();
            end
            adc_ch1 = stim[s][7:0];   adc_ch2 = stim[s][15:8];  adc_ch3 = stim[s][23:16];
            adc_ch4 = stim[s][31:24]; adc_ch5 = stim[s][39:32]; adc_ch6 = stim[s][47:40];
            adc_valid = 1'b1;
            capture_start = (wi == ignore_at);
            step();
            adc_valid = 1'b0;
            capture_start = 1'b0;
            if (wi == collide_at) begin
                n_total++;
                if (got_word !== exp_mem[wi]) $display("FAIL collide_old: got %h want %h", got_word, exp_mem[wi]);
                else n_pass++;
                n_total++;
                if (read_new_sample !== 1'b0) $display("FAIL collide_pulse: got %b want 0", read_new_sample);
                else n_pass++;
            end
            if (wi == ignore_at) begin
                n_total++;
                if (capture_busy !== 1'b1) $display("FAIL ignore_busy: got %b want 1", capture_busy);
                else n_pass++;
            end
            if (wi < DEPTH - 1) repeat ($urandom_range(gap_max)) step();
        end
        step();
        n_total++;
        if (writing_finish_flag !== 1'b1) $display("FAIL finish_flag: got %b want 1", writing_finish_flag);
        else n_pass++;
        n_total++;
        if (capture_busy !== 1'b0) $display("FAIL finish_busy: got %b want 0", capture_busy);
        else n_pass++;
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = stim[trig + k];
        model_flag = 1'b1;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        adc_ch1 = 8'd0; adc_ch2 = 8'd0; adc_ch3 = 8'd0;
        adc_ch4 = 8'd0; adc_ch5 = 8'd0; adc_ch6 = 8'd0;
        adc_valid = 1'b0; capture_start = 1'b0; read_address = 12'd0;
        prev_req = 12'd0; model_flag = 1'b0;
        #3;
        n_total++;
        if ({got_word, read_new_sample, writing_finish_flag, capture_busy} !== 51'd0)
            $display("FAIL reset_outputs: got %h/%b/%b/%b want all 0", got_word,
                     read_new_sample, writing_finish_flag, capture_busy);
        else n_pass++;
        repeat (3) step();
        reset_reset_n = 1'b1;
        step();
        n_total++;
        if ({read_new_sample, writing_finish_flag, capture_busy} !== 3'b000)
            $display("FAIL reset_release: got %b%b%b want 000", read_new_sample,
                     writing_finish_flag, capture_busy);
        else n_pass++;
    endtask

    task automatic test_full_capture();
        read_address = 12'd4000;
        prev_req = 12'd4000;
        arm();
        capture(0, 0, 100, -1, -1);
    endtask

    task automatic test_read_back();
        do_read(12'd0);
        do_read(12'd1);
        do_read(12'd4095);
        repeat (10) begin
            step();
            n_total++;
            if (read_new_sample !== 1'b0) $display("FAIL hold_pulse: got %b want 0", read_new_sample);
            else n_pass++;
        end
        repeat (3) do_read(12'($urandom_range(4095)));
    endtask

    task automatic test_restart_in_done();
        arm();
        do_read(12'($urandom_range(4095)));
    endtask

    task automatic test_collision();
        capture(1, 2, -1, 700, -1);
        do_read(12'd700);
        do_read(12'($urandom_range(4095)));
    endtask

    task automatic test_reset_mid_capture();
        arm();
        capture(1, 1, -1, -1, 2000);
        arm();
        capture(1, 1, -1, -1, -1);
        repeat (3) do_read(12'($urandom_range(4095)));
    endtask

    task automatic test_trigger();
        logic [7:0] want_ch1;
`ifdef ZERO_CROSS_TRIG_EN
        want_ch1 = 8'd128;
`else
        want_ch1 = 8'd200;
`endif
        arm();
        capture(2, 1, -1, -1, -1);
        do_read(12'd5);
        do_read(12'd0);
        n_total++;
        if (channel1_analog !== want_ch1) $display("FAIL trigger_addr0: got %0d want %0d", channel1_analog, want_ch1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_capture();
        test_read_back();
        test_restart_in_done();
        test_collision();
        test_reset_mid_capture();
        test_trigger();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Capture-side counterpart to the Nios II sample reader. It takes six 8-bit ADC channel samples per strobe and writes a block of 4096 sample-sets into on-chip RAM. When the block is full it raises `writing_finish_flag`. It then serves the stored samples to the Nios II section: that section drives `read_address`, and this block returns the six channel bytes together with a `read_new_sample` pulse. It sits between the ADC front-end interface and the `channelN_analog`, `read_address`, `read_new_sample` and `writing_finish_flag` PIO ports of the processor system.

## Interface
- `ADDR_W`, 12, buffer address width; depth = 2^ADDR_W sample-sets.
- `DATA_W`, 8, width per channel.
- `TRIG_LEVEL`, 8'd128, mid-scale threshold used by the zero-cross trigger.

Ports:
- `clk_clk`  in  1  system clock. One clock domain.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `adc_ch1`..`adc_ch6`  in  DATA_W each  ADC samples, offset binary.
- `adc_valid`  in  1  one-cycle strobe; all six `adc_chN` are valid while it is high.
- `capture_start`  in  1  one-cycle pulse that arms a new capture.
- `read_address`  in  ADDR_W  sample-set index requested by the processor.
- `channel1_analog`..`channel6_analog`  out  DATA_W each  stored samples for the requested index.
- `read_new_sample`  out  1  one-cycle pulse when `channelN_analog` hold data for a newly requested address.
- `writing_finish_flag`  out  1  high while a complete block is held in RAM.
- `capture_busy`  out  1  high in ARMED or WRITE.

## Operation
- RAM is 2^ADDR_W words × 6·DATA_W bits, with one write port and one registered read port.
- States:
  - IDLE: entered at reset.
  - ARMED: waiting for the trigger condition.
  - WRITE: filling RAM.
  - DONE: block complete.
- Transitions:
  - IDLE or DONE with `capture_start` → ARMED. In the same cycle: `writing_finish_flag` ← 0, write pointer ← 0.
  - ARMED → WRITE when the trigger condition holds (see Configuration). That trigger sample is stored at address 0.
  - WRITE: each `adc_valid` writes {ch6..ch1} at the write pointer, then the pointer increments. The write at pointer 2^ADDR_W−1 → DONE, and `writing_finish_flag` ← 1 on the following edge.
  - `capture_start` while in ARMED or WRITE is ignored.
- Write pointer does not wrap. Exactly 2^ADDR_W writes are made per capture.
- Read side runs in every state.
  - `read_address` is registered and used to address RAM. The registered RAM output drives `channelN_analog`.
  - When the registered address differs from the previous registered address, `read_new_sample` pulses in the cycle the new data appear.
  - `read_new_sample` is suppressed (held 0) unless `writing_finish_flag` = 1.
- Read and write to the same address in the same cycle: the read returns the old data.
- Reset mid-capture: state → IDLE, all outputs 0. RAM contents are retained but are not flagged valid.

## Timing
- Reset values:
  - `channelN_analog` = 0
  - `read_new_sample` = 0
  - `writing_finish_flag` = 0
  - `capture_busy` = 0
  - internal last-address register = 0, so address 0 after reset yields no pulse.
- Read latency: `read_address` changes before edge N. It is registered at edge N, RAM is read at edge N+1, and data plus `read_new_sample` are valid after edge N+1. The pulse is exactly one cycle wide.
- An unchanged `read_address` produces no further pulses.
- `writing_finish_flag` rises one cycle after the final write and falls one cycle after an accepted `capture_start`.
- `capture_busy` rises one cycle after `capture_start` and falls in the same cycle `writing_finish_flag` rises.
- The minimum `adc_valid` spacing is 1 cycle (back-to-back strobes accepted).

## Configuration
- `ZERO_CROSS_TRIG_EN`
  - Defined: ARMED stores the channel-1 value on each `adc_valid`. The trigger fires on the first strobe where the previous ch1 < TRIG_LEVEL and the current ch1 ≥ TRIG_LEVEL. The first strobe after arming only loads the previous value and cannot fire.
  - Undefined: the trigger fires on the first `adc_valid` in ARMED, and there is no stored-previous register.

## Test plan
- Reset → all outputs 0. Then `capture_start`, then 4096 consecutive `adc_valid` with chN = (index+N)&0xFF → `writing_finish_flag` = 1 one cycle after the last strobe, and `capture_busy` = 0.
- After a full capture, step `read_address` through 0, 1, 4095 → each produces one `read_new_sample` pulse 2 edges later, with ch1 = 1, 2, 0 and ch6 = 6, 7, 5. Holding the address for 10 cycles produces no further pulses.
- `capture_start` mid-WRITE at pointer 100 → ignored, and the capture completes at 4096 writes. `capture_start` in DONE → flag drops after 1 cycle and reads are suppressed.
- Assert reset at pointer 2000 → IDLE with outputs 0. A new capture then completes normally.
- `ZERO_CROSS_TRIG_EN` defined, with ch1 sequence 200, 100, 127, 128, 130 after arming → the value 128 is stored at address 0. Undefined → 200 is stored at address 0.
- Same-address read/write collision during WRITE → the old word is returned and `read_new_sample` stays 0.
